mdu: RTL and testbench
======================

# mdu

Multiply/divide unit beside the ALU in the execute stage. It takes the two register operands (GRF RD1 → A, GRF RD2 → B) and runs mult/multu/div/divu over several cycles into private HI/LO registers. It also serves mthi/mtlo writes and feeds HI/LO to the write-back mux for mfhi/mflo. `busy` tells control to stall any later MDU instruction.

## Interface
- `MULT_CYCLES`, 5: cycles from accepted multiply to HI/LO update (≥1).
- `DIV_CYCLES`, 10: cycles from accepted divide to HI/LO update (≥1).

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `start` input 1: one-cycle request qualifier for `MDUOp`.
- `MDUOp` input 4: operation code, encodings from the shared package.
- `A` input 32: operand rs.
- `B` input 32: operand rt.
- `busy` output 1: high while an operation is in flight.
- `HI` output 32: current HI register.
- `LO` output 32: current LO register.

## Operation
- Ops: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO. MADD/MADDU/MSUB/MSUBU exist only with the macro (see Configuration).
- States: IDLE, RUN.
- IDLE, `start`=1, MULT/MULTU/DIV/DIVU:
  - latch the result into pending registers;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- IDLE, `start`=1, MTHI/MTLO: write A into HI or LO at that edge; stay IDLE; `busy` stays 0.
- IDLE, `start`=1, NONE or unknown code: no effect.
- RUN: counter decrements each edge. On the edge where it reaches 1:
  - HI/LO take the pending result;
  - go to IDLE.
- `start` during RUN (any op, MTHI/MTLO included) is ignored. Control stalls while `busy`=1.
- Arithmetic:
  - MULT: signed 32×32→64.
  - MULTU: unsigned 32×32→64.
  - Multiply results: HI = bits 63:32, LO = bits 31:0.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; remainder takes the dividend's sign.
- Boundary rules:
  - Divide by zero, signed or unsigned: LO = 32'hFFFFFFFF, HI = A.
  - Signed overflow 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
  - Operands are sampled only at the accepting edge. Later changes on A/B do not affect the result.

## Timing
- Reset values: HI = 0, LO = 0, `busy` = 0, state IDLE, counter 0, pending regs 0.
- Reset asserted mid-RUN aborts the operation at once. The pending result is discarded and never reaches HI/LO.
- Op accepted at edge 0:
  - `busy` = 1 after edge 0 through edge N−1;
  - HI/LO update at edge N, with N = MULT_CYCLES or DIV_CYCLES;
  - `busy` falls at edge N.
- A new `start` is accepted at edge N+1 at the earliest.
- MTHI/MTLO: HI/LO visible one edge after `start`.
- HI/LO are plain register outputs; there is no combinational path from A/B.
- mfhi in the cycle `busy` falls reads the new value.

## Configuration
- `MDU_MADD_EN` defined:
  - MADD/MADDU/MSUB/MSUBU are decoded.
  - They use MULT_CYCLES latency.
  - Pending = {HI,LO} ± the signed/unsigned 64-bit product, computed from the HI/LO values at the accepting edge. The sum wraps mod 2^64.
- `MDU_MADD_EN` undefined: those four codes are treated as NONE (no effect, `busy` stays 0).

## Structure
- Shared package `mdu_pkg`:
  - MDUOp encodings (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10);
  - state encoding;
  - default cycle constants.
- The control unit uses the same package to drive `MDUOp`.
- One sub-module, `mdu_calc`: combinational 64-bit result from op, A, B, HI, LO, including the divide-by-zero/overflow rules.
- The top level keeps the FSM, counter, and pending/HI/LO registers.

## Test plan
- MULT, A=32'hFFFFFFFE (−2), B=3:
  - `busy` high 5 cycles;
  - then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
- MULTU, A=B=32'hFFFFFFFF: HI=32'hFFFFFFFE, LO=32'h00000001 after 5 cycles.
- DIV, A=−7, B=2: after 10 cycles LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIV, A=32'h80000000, B=32'hFFFFFFFF: LO=32'h80000000, HI=0.
- DIVU, A=5, B=0: LO=32'hFFFFFFFF, HI=5.
- Busy-time behaviour:
  - MTHI A=32'h12345678 while idle: HI=32'h12345678 next cycle.
  - MTLO issued mid-DIV: ignored.
  - Reset pulsed at cycle 4 of a DIV: HI=LO=0, `busy`=0, no later update.
  - With `MDU_MADD_EN`, HI:LO = 0:1, then MADD A=B=2: HI:LO = 0:5.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states and default latencies for the multiply/divide unit.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU codes.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int CNT_W = 16;

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational 64-bit {HI,LO} result for one MDU op.
// MDU_MADD_EN adds the accumulate/subtract forms.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic signed [63:0] sa64, sb64, sprod;
  logic        [63:0] uprod;
  logic signed [31:0] sa, sb, sq, sr;
  logic        [31:0] uq, ur;
  logic               div0, ovf;

  assign sa64  = {{32{a[31]}}, a};
  assign sb64  = {{32{b[31]}}, b};
  assign sprod = sa64 * sb64;
  assign uprod = {32'd0, a} * {32'd0, b};

  assign sa   = a;
  assign sb   = b;
  assign div0 = (b == 32'd0);
  // the only signed quotient that does not fit in 32 bits
  assign ovf  = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
  assign sq   = sa / sb;
  assign sr   = sa % sb;
  assign uq   = a / b;
  assign ur   = a % b;

  always_comb begin
    res = {hi, lo};
    case (op)
      MDU_MULT:  res = sprod;
      MDU_MULTU: res = uprod;
      MDU_DIV: begin
        if (div0)
          res = {a, 32'hffff_ffff};
        else if (ovf)
          res = {32'd0, 32'h8000_0000};
        else
          res = {sr, sq};
      end
      MDU_DIVU: begin
        if (div0)
          res = {a, 32'hffff_ffff};
        else
          res = {ur, uq};
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  res = {hi, lo} + sprod;
      MDU_MADDU: res = {hi, lo} + uprod;
      MDU_MSUB:  res = {hi, lo} - sprod;
      MDU_MSUBU: res = {hi, lo} - uprod;
`endif
      default:   res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with private HI/LO and busy stall.
// MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (multiply latency).
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [31:0]      hi_q, lo_q, pend_hi, pend_lo;
  logic [63:0]      res;
  logic             is_mul, is_div, is_mthi, is_mtlo;
  logic             acc, wr_hi, wr_lo, fin;

  mdu_calc u_calc (
    .op  (MDUOp),
    .a   (A),
    .b   (B),
    .hi  (hi_q),
    .lo  (lo_q),
    .res (res)
  );

  always_comb begin
    is_mul  = (MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU);
`ifdef MDU_MADD_EN
    is_mul  = is_mul ||
              (MDUOp inside {MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU});
`endif
    is_div  = (MDUOp == MDU_DIV) || (MDUOp == MDU_DIVU);
    is_mthi = (MDUOp == MDU_MTHI);
    is_mtlo = (MDUOp == MDU_MTLO);
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    acc     = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    fin     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_mul: begin
              acc     = 1'b1;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = S_RUN;
            end
            is_div: begin
              acc     = 1'b1;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = S_RUN;
            end
            is_mthi: wr_hi = 1'b1;
            is_mtlo: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cnt == CNT_W'(1)) begin
          fin     = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      cnt <= cnt_d;
      if (acc)
        {pend_hi, pend_lo} <= res;
      if (wr_hi)
        hi_q <= A;
      if (wr_lo)
        lo_q <= A;
      if (fin) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end
    end
  end

  assign busy = (state == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: table vectors, corner sequences and random ops against a
// plain-arithmetic HI/LO model.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  MDUOp;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDUOp (MDUOp),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tv [14];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int lat(input logic [3:0] op);
    lat = 0;
    if (op == MDU_MULT || op == MDU_MULTU) lat = 5;
    if (op == MDU_DIV || op == MDU_DIVU) lat = 10;
`ifdef MDU_MADD_EN
    if (op >= MDU_MADD && op <= MDU_MSUBU) lat = 5;
`endif
  endfunction

  function automatic logic [63:0] ref_op(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] hi, input logic [31:0] lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ref_op = {hi, lo};
    case (op)
      MDU_MULT:  ref_op = sa * sb;
      MDU_MULTU: ref_op = ua * ub;
      MDU_DIV: begin
        if (b == 0) ref_op = {a, 32'hffff_ffff};
        else begin
          q = sa / sb;
          r = sa % sb;
          ref_op = {r[31:0], q[31:0]};
        end
      end
      MDU_DIVU: begin
        if (b == 0) ref_op = {a, 32'hffff_ffff};
        else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
          ref_op = {r[31:0], q[31:0]};
        end
      end
      MDU_MTHI: ref_op = {a, lo};
      MDU_MTLO: ref_op = {hi, a};
`ifdef MDU_MADD_EN
      MDU_MADD:  ref_op = {hi, lo} + sa * sb;
      MDU_MADDU: ref_op = {hi, lo} + ua * ub;
      MDU_MSUB:  ref_op = {hi, lo} - sa * sb;
      MDU_MSUBU: ref_op = {hi, lo} - ua * ub;
`endif
      default: ;
    endcase
  endfunction

  // returns one step after the accepting edge; operands are scrambled then
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    MDUOp = op;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    MDUOp = 4'($urandom);
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_idle(output int cyc, output logic held);
    cyc = 0;
    held = 1'b1;
    while (busy && cyc < 200) begin
      if (HI !== m_hi || LO !== m_lo) held = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int n, cyc;
    logic held;
    exp = ref_op(op, a, b, m_hi, m_lo);
    n = lat(op);
    issue(op, a, b);
    if (n == 0) begin
      chk({name, " busy"}, {31'd0, busy}, 32'd0);
    end else begin
      chk({name, " busy rise"}, {31'd0, busy}, 32'd1);
      wait_idle(cyc, held);
      chk({name, " latency"}, cyc, n);
      chk({name, " hold"}, {31'd0, held}, 32'd1);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    chk({name, " HI"}, HI, m_hi);
    chk({name, " LO"}, LO, m_lo);
  endtask

  initial begin
    logic [63:0] exp;
    int cyc;
    logic held;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [3:0] ops [8];

    tv[0]  = '{MDU_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h0};
    tv[1]  = '{MDU_MTLO,  32'hcafef00d, 32'h0,        32'h12345678, 32'hcafef00d};
    tv[2]  = '{MDU_MULT,  32'hfffffffe, 32'd3,        32'hffffffff, 32'hfffffffa};
    tv[3]  = '{MDU_MULTU, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001};
    tv[4]  = '{MDU_DIV,   32'hfffffff9, 32'd2,        32'hffffffff, 32'hfffffffd};
    tv[5]  = '{MDU_DIV,   32'h80000000, 32'hffffffff, 32'h0,        32'h80000000};
    tv[6]  = '{MDU_DIVU,  32'd5,        32'd0,        32'd5,        32'hffffffff};
    tv[7]  = '{MDU_DIV,   32'hfffffff9, 32'd0,        32'hfffffff9, 32'hffffffff};
    tv[8]  = '{MDU_DIV,   32'd7,        32'hfffffffe, 32'd1,        32'hfffffffd};
    tv[9]  = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    tv[10] = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
    tv[11] = '{MDU_NONE,  32'd1,        32'd1,        32'h40000000, 32'h0};
    tv[12] = '{4'd11,     32'd9,        32'd9,        32'h40000000, 32'h0};
    tv[13] = '{MDU_MULT,  32'd7,        32'hfffffffd, 32'hffffffff, 32'hffffffeb};

    reset = 1'b0;
    start = 1'b0;
    MDUOp = MDU_NONE;
    A = '0;
    B = '0;
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b);
      chk($sformatf("vec%0d tbl HI", i), HI, tv[i].hi);
      chk($sformatf("vec%0d tbl LO", i), LO, tv[i].lo);
    end

    // MTLO/MTHI while a divide runs must be dropped
    exp = ref_op(MDU_DIV, 32'd100, 32'd7, m_hi, m_lo);
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    MDUOp = MDU_MTLO;
    A = 32'hdeadbeef;
    @(negedge clk);
    MDUOp = MDU_MTHI;
    A = 32'hbadc0ffe;
    @(negedge clk);
    start = 1'b0;
    chk("middiv HI hold", HI, m_hi);
    chk("middiv LO hold", LO, m_lo);
    wait_idle(cyc, held);
    chk("middiv done", {31'd0, busy}, 32'd0);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    chk("middiv HI", HI, 32'd2);
    chk("middiv LO", LO, 32'd14);
    repeat (2) @(posedge clk);
    #1;
    chk("middiv LO after", LO, 32'd14);

    // reset during cycle 4 of a divide
    issue(MDU_DIV, 32'd1000, 32'd3);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst HI", HI, 32'd0);
    chk("rst LO", LO, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    repeat (15) @(posedge clk);
    #1;
    chk("rst later HI", HI, 32'd0);
    chk("rst later LO", LO, 32'd0);
    chk("rst later busy", {31'd0, busy}, 32'd0);

`ifdef MDU_MADD_EN
    run_op("madd mthi", MDU_MTHI, 32'd0, 32'd0);
    run_op("madd mtlo", MDU_MTLO, 32'd1, 32'd0);
    run_op("madd", MDU_MADD, 32'd2, 32'd2);
    chk("madd HI", HI, 32'd0);
    chk("madd LO", LO, 32'd5);
`else
    run_op("madd off mtlo", MDU_MTLO, 32'd1, 32'd0);
    run_op("madd off", MDU_MADD, 32'd2, 32'd2);
    chk("madd off LO", LO, 32'd1);
    run_op("msubu off", MDU_MSUBU, 32'd3, 32'd3);
`endif

    ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU,
            MDU_MTHI, MDU_MTLO, MDU_NONE, 4'd15};
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 7)];
      if (op == 4'd15) op = 4'($urandom_range(7, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hffffffff; end
        2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
        3: b = 32'hffffffff - $urandom_range(0, 9);
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), op, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
